// File: rtl/noc_mem_pkg.sv
// rtl/noc_mem_pkg.sv - opcodes, packet byte offsets, lengths and request record for the NOC line memory node
package noc_mem_pkg;

    localparam logic [7:0] OP_READ    = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_ACK_BIT = 8'h80;
    localparam logic [7:0] OP_ERR     = 8'hFF;

    localparam int HDR_DST  = 0;
    localparam int HDR_SRC  = 1;
    localparam int HDR_OP   = 2;
    localparam int HDR_ADDR = 3;
    localparam int HDR_DATA = 7;

    localparam logic [5:0] RSP_LEN_RD  = 6'd23;
    localparam logic [5:0] RSP_LEN_WR  = 6'd7;
    localparam logic [5:0] REQ_MIN_LEN = 6'd7;

    typedef struct packed {
        logic [7:0]       src;
        logic [7:0]       opcode;
        logic [31:0]      addr;
        logic [15:0][7:0] data;
    } noc_mem_req;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } noc_mem_state_e;

endpackage

// File: rtl/noc_line_ram.sv
// rtl/noc_line_ram.sv - single-port synchronous line RAM, registered read, no reset
module noc_line_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 128,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/noc_line_mem_responder.sv
// rtl/noc_line_mem_responder.sv - NOC memory node serving single-beat line read/write requests
// Define NOC_MEM_ERR_RESP_EN to answer malformed beats addressed here with an error packet.
module noc_line_mem_responder
    import noc_mem_pkg::*;
#(
    parameter logic [3:0] NODE_ADDR   = 4'h1,
    parameter logic [3:0] NODE_PORT   = 4'h0,
    parameter int         LINE_BYTES  = 16,
    parameter int         MEM_LINES   = 256,
    parameter int         MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0][7:0] noc_bus_inp_dat,
    input  logic [5:0]       noc_bus_inp_bp,
    output logic             noc_bus_inp_bo,
    output logic [31:0][7:0] noc_bus_oup_dat,
    output logic [5:0]       noc_bus_oup_bp,
    input  logic             noc_bus_oup_bo
);

    localparam int             AW       = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int             CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LATENCY - 1);
    localparam logic [7:0]     NODE_ID  = {NODE_PORT, NODE_ADDR};
    localparam logic [31:0]    LINES_U  = 32'(MEM_LINES);

    noc_mem_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    noc_mem_req     req_q, req_d;
    logic [7:0]     rsp_op_q, rsp_op_d;
    logic [5:0]     rsp_len_q, rsp_len_d;

    logic                    mem_we, mem_re;
    logic [LINE_BYTES*8-1:0] mem_rdata;

    logic [7:0]  in_op;
    logic [31:0] in_addr;
    logic        hdr_hit, op_ok, idx_ok, len_ok, accept;
    logic        unused_inp;

    assign in_op   = noc_bus_inp_dat[HDR_OP];
    assign in_addr = noc_bus_inp_dat[HDR_ADDR +: 4];
    assign hdr_hit = (noc_bus_inp_bp != '0) && (noc_bus_inp_dat[HDR_DST] == NODE_ID);
    assign op_ok   = (in_op == OP_READ) || (in_op == OP_WRITE);
    assign idx_ok  = {4'b0, in_addr[31:4]} < LINES_U;
    assign len_ok  = noc_bus_inp_bp >= REQ_MIN_LEN;
    assign accept  = hdr_hit && op_ok && idx_ok && len_ok;

    assign unused_inp = ^noc_bus_inp_dat[31:HDR_DATA+16];

`ifdef NOC_MEM_ERR_RESP_EN
    // Bytes beyond the received length are reported as zero, not as bus residue.
    logic [31:0] err_addr;
    logic [7:0]  err_src;
    always_comb begin
        err_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (noc_bus_inp_bp > 6'(HDR_ADDR + i)) begin
                err_addr[8*i +: 8] = noc_bus_inp_dat[HDR_ADDR + i];
            end
        end
        err_src = (noc_bus_inp_bp > 6'(HDR_SRC)) ? noc_bus_inp_dat[HDR_SRC] : '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            rsp_op_q  <= '0;
            rsp_len_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            rsp_op_q  <= rsp_op_d;
            rsp_len_q <= rsp_len_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        rsp_op_d       = rsp_op_q;
        rsp_len_d      = rsp_len_q;
        noc_bus_inp_bo = 1'b1;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        case (state_q)
            IDLE: begin
                noc_bus_inp_bo = 1'b0;
                if (accept) begin
                    req_d.src    = noc_bus_inp_dat[HDR_SRC];
                    req_d.opcode = in_op;
                    req_d.addr   = in_addr;
                    req_d.data   = noc_bus_inp_dat[HDR_DATA +: 16];
                    rsp_op_d     = in_op | OP_ACK_BIT;
                    rsp_len_d    = (in_op == OP_READ) ? RSP_LEN_RD : RSP_LEN_WR;
                    cnt_d        = '0;
                    state_d      = ACCESS;
                end
`ifdef NOC_MEM_ERR_RESP_EN
                else if (hdr_hit) begin
                    req_d.src    = err_src;
                    req_d.opcode = in_op;
                    req_d.addr   = err_addr;
                    req_d.data   = '0;
                    rsp_op_d     = OP_ERR;
                    rsp_len_d    = RSP_LEN_WR;
                    state_d      = RESPOND;
                end
`endif
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    mem_we  = (req_q.opcode == OP_WRITE);
                    mem_re  = (req_q.opcode == OP_READ);
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESPOND: begin
                if (!noc_bus_oup_bo) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response is assembled from the latched request and the RAM read register.
    always_comb begin
        noc_bus_oup_dat = '0;
        noc_bus_oup_bp  = '0;
        if (state_q == RESPOND) begin
            noc_bus_oup_bp                  = rsp_len_q;
            noc_bus_oup_dat[HDR_DST]        = req_q.src;
            noc_bus_oup_dat[HDR_SRC]        = NODE_ID;
            noc_bus_oup_dat[HDR_OP]         = rsp_op_q;
            noc_bus_oup_dat[HDR_ADDR +: 4]  = req_q.addr;
            if (rsp_op_q == (OP_READ | OP_ACK_BIT)) begin
                noc_bus_oup_dat[HDR_DATA +: LINE_BYTES] = mem_rdata;
            end
        end
    end

    noc_line_ram #(
        .DEPTH (MEM_LINES),
        .DW    (LINE_BYTES * 8)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (req_q.addr[4 +: AW]),
        .wdata_i (req_q.data),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_noc_line_mem_responder.sv
// tb/tb_noc_line_mem_responder.sv - table-driven check of the NOC line memory responder
module tb_noc_line_mem_responder;

    localparam int LAT = 4;
`ifdef NOC_MEM_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    localparam logic [127:0] PAT0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] PAT1 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
    localparam logic [127:0] JUNK = {16{8'hAA}};

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0][7:0] inp_dat;
    logic [5:0]       inp_bp;
    logic             inp_bo;
    logic [31:0][7:0] oup_dat;
    logic [5:0]       oup_bp;
    logic             oup_bo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noc_line_mem_responder #(
        .NODE_ADDR   (4'h1),
        .NODE_PORT   (4'h0),
        .LINE_BYTES  (16),
        .MEM_LINES   (256),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .noc_bus_inp_dat (inp_dat),
        .noc_bus_inp_bp  (inp_bp),
        .noc_bus_inp_bo  (inp_bo),
        .noc_bus_oup_dat (oup_dat),
        .noc_bus_oup_bp  (oup_bp),
        .noc_bus_oup_bo  (oup_bo)
    );

    typedef struct {
        string        name;
        logic [7:0]   dst;
        logic [7:0]   src;
        logic [7:0]   op;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [5:0]   bp;
        logic         exp_rsp;
        logic [5:0]   exp_bp;
        logic [7:0]   exp_op;
        logic [31:0]  exp_addr;
        logic [127:0] exp_data;
        int           exp_lat;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input string nm, input logic [7:0] dst, input logic [7:0] src,
                                input logic [7:0] op, input logic [31:0] addr, input logic [127:0] wd,
                                input logic [5:0] bp, input logic er, input logic [5:0] ebp,
                                input logic [7:0] eop, input logic [31:0] ea, input logic [127:0] ed,
                                input int el);
        vec_t v;
        v.name = nm; v.dst = dst; v.src = src; v.op = op; v.addr = addr; v.wdata = wd; v.bp = bp;
        v.exp_rsp = er; v.exp_bp = ebp; v.exp_op = eop; v.exp_addr = ea; v.exp_data = ed; v.exp_lat = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        @(negedge clk);
        inp_dat       = '0;
        inp_dat[0]    = v.dst;
        inp_dat[1]    = v.src;
        inp_dat[2]    = v.op;
        inp_dat[6:3]  = v.addr;
        inp_dat[22:7] = v.wdata;
        inp_bp        = v.bp;
        @(posedge clk);
        #1;
        inp_bp  = '0;
        inp_dat = '0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (oup_bp != '0 || inp_bo != 1'b0) bad++;
        end
        check(name, 256'(bad), 256'(0));
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0][7:0] ed;
        int lat;
        send(v);
        if (v.exp_rsp) begin
            @(negedge clk);
            lat = 1;
            check($sformatf("%s inp_bo_busy", v.name), 256'(inp_bo), 256'(1'b1));
            while (oup_bp == '0 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("%s latency", v.name), 256'(lat), 256'(v.exp_lat));
            check($sformatf("%s bp", v.name), 256'(oup_bp), 256'(v.exp_bp));
            ed        = '0;
            ed[0]     = v.src;
            ed[1]     = 8'h01;
            ed[2]     = v.exp_op;
            ed[6:3]   = v.exp_addr;
            ed[22:7]  = v.exp_data;
            check($sformatf("%s dat", v.name), oup_dat, ed);
            @(negedge clk);
            check($sformatf("%s done_bp", v.name), 256'(oup_bp), 256'(0));
            check($sformatf("%s done_bo", v.name), 256'(inp_bo), 256'(1'b0));
        end else begin
            expect_quiet($sformatf("%s quiet", v.name), 8);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0][7:0] snap;
        int bad;
        int wait_cnt;

        //              name        dst    src    op     addr          wdata  bp     rsp     ebp    eop    eaddr         edata  lat
        vecs[0]  = mk("wr40",      8'h01, 8'h23, 8'h02, 32'h0000_0040, PAT0, 6'd23, 1'b1,   6'd7,  8'h82, 32'h0000_0040, '0,   LAT+1);
        vecs[1]  = mk("rd40",      8'h01, 8'h23, 8'h01, 32'h0000_0040, '0,   6'd7,  1'b1,   6'd23, 8'h81, 32'h0000_0040, PAT0, LAT+1);
        vecs[2]  = mk("dst_miss",  8'h05, 8'h23, 8'h02, 32'h0000_0040, JUNK, 6'd23, 1'b0,   6'd0,  8'h00, 32'h0,         '0,   0);
        vecs[3]  = mk("rd40_again",8'h01, 8'h37, 8'h01, 32'h0000_0040, '0,   6'd23, 1'b1,   6'd23, 8'h81, 32'h0000_0040, PAT0, LAT+1);
        vecs[4]  = mk("oor",       8'h01, 8'h23, 8'h01, 32'h0000_1000, '0,   6'd7,  ERR_EN, 6'd7,  8'hFF, 32'h0000_1000, '0,   1);
        vecs[5]  = mk("bad_op",    8'h01, 8'h23, 8'h03, 32'h0000_0040, '0,   6'd7,  ERR_EN, 6'd7,  8'hFF, 32'h0000_0040, '0,   1);
        vecs[6]  = mk("wrFF",      8'h01, 8'h11, 8'h02, 32'h0000_0FF5, PAT1, 6'd23, 1'b1,   6'd7,  8'h82, 32'h0000_0FF5, '0,   LAT+1);
        vecs[7]  = mk("rdFF",      8'h01, 8'h11, 8'h01, 32'h0000_0FF0, '0,   6'd7,  1'b1,   6'd23, 8'h81, 32'h0000_0FF0, PAT1, LAT+1);
        vecs[8]  = mk("short",     8'h01, 8'h23, 8'h01, 32'h0001_2340, '0,   6'd5,  ERR_EN, 6'd7,  8'hFF, 32'h0000_2340, '0,   1);
        vecs[9]  = mk("port_miss", 8'h11, 8'h23, 8'h01, 32'h0000_0040, '0,   6'd7,  1'b0,   6'd0,  8'h00, 32'h0,         '0,   0);
        vecs[10] = mk("idle_bp0",  8'h01, 8'h23, 8'h01, 32'h0000_0040, '0,   6'd0,  1'b0,   6'd0,  8'h00, 32'h0,         '0,   0);

        rst     = 1'b1;
        inp_dat = '0;
        inp_bp  = '0;
        oup_bo  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset inp_bo", 256'(inp_bo), 256'(1'b0));
        check("reset oup_bp", 256'(oup_bp), 256'(0));
        check("reset oup_dat", oup_dat, 256'(0));
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: response must hold still while downstream is occupied.
        oup_bo = 1'b1;
        send(vecs[7]);
        wait_cnt = 0;
        while (oup_bp == '0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("bp_hold first_bp", 256'(oup_bp), 256'(6'd23));
        snap = oup_dat;
        check("bp_hold data", 256'(snap[22:7]), 256'(PAT1));
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (oup_dat !== snap || oup_bp !== 6'd23 || inp_bo !== 1'b1) bad++;
        end
        check("bp_hold stable", 256'(bad), 256'(0));
        oup_bo = 1'b0;
        @(negedge clk);
        check("bp_release bp", 256'(oup_bp), 256'(0));
        check("bp_release inp_bo", 256'(inp_bo), 256'(1'b0));

        // Reset asserted while a READ sits in ACCESS.
        send(vecs[1]);
        @(negedge clk);
        check("rst_mid in_access", 256'(inp_bo), 256'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid oup_bp", 256'(oup_bp), 256'(0));
        check("rst_mid inp_bo", 256'(inp_bo), 256'(1'b0));
        check("rst_mid oup_dat", oup_dat, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("rst_mid no_rsp", 10);
        run_vec(vecs[1]);
        run_vec(vecs[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
